// File: rtl/expo_sensor_writer_if.sv
// Sensor register-write command channel: 16-bit address, 8-bit data, valid/ready.
// The writer drives the master side; the SCCB/I2C master sits on the slave side.
interface expo_sensor_writer_if;
  logic        cmd_valid;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/expo_sensor_writer.sv
// Clamps the AE exposure on each frame strobe and writes it to the sensor as H/M/L register writes.
// First command one cycle after the strobe; each command is held until cmd_ready, so a stall just stretches the sequence.
module expo_sensor_writer #(
  parameter logic [23:0] EXPO_MAX       = 24'h0FFFFF,
  parameter logic [23:0] EXPO_MIN       = 24'h000010,
  parameter logic [23:0] EXPO_INIT      = 24'h011264,
  parameter logic [15:0] REG_EXPO_H     = 16'h3500,
  parameter logic [15:0] REG_EXPO_M     = 16'h3501,
  parameter logic [15:0] REG_EXPO_L     = 16'h3502,
  parameter bit          USE_GROUP_HOLD = 1'b1,
  parameter logic [15:0] REG_GROUP      = 16'h3212
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_new,
  input  logic [23:0]          expo_in,
  expo_sensor_writer_if.master cmd,
  output logic                 busy,
  output logic                 update_done,
  output logic [23:0]          applied_expo,
  output logic [7:0]           overrun_cnt
);

  typedef enum logic [2:0] {
    IDLE, GH_START, WR_H, WR_M, WR_L, GH_END, GH_LAUNCH
  } state_t;

  localparam state_t FIRST = USE_GROUP_HOLD ? GH_START : WR_H;

  state_t      state_q, state_d;
  logic [23:0] pend_q, pend_d;
  logic [23:0] applied_q, applied_d;
  logic [7:0]  ovr_q, ovr_d;
  logic        primed_q, primed_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [15:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]  cmd_data_q, cmd_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [23:0] ec;
  logic        hs;
  state_t      nxt;

  function automatic logic [23:0] cmd_word(input state_t s, input logic [23:0] e);
    logic [23:0] w;
    case (s)
      GH_START:  w = {REG_GROUP, 8'h00};
      WR_H:      w = {REG_EXPO_H, 4'h0, e[19:16]};
      WR_M:      w = {REG_EXPO_M, e[15:8]};
      WR_L:      w = {REG_EXPO_L, e[7:0]};
      GH_END:    w = {REG_GROUP, 8'h10};
      GH_LAUNCH: w = {REG_GROUP, 8'hA0};
      default:   w = 24'h000000;
    endcase
    return w;
  endfunction

  // IDLE as a successor marks the final command of the sequence.
  function automatic state_t next_of(input state_t s);
    state_t n;
    case (s)
      GH_START: n = WR_H;
      WR_H:     n = WR_M;
      WR_M:     n = WR_L;
      WR_L:     n = USE_GROUP_HOLD ? GH_END : IDLE;
      GH_END:   n = GH_LAUNCH;
      default:  n = IDLE;
    endcase
    return n;
  endfunction

  always_comb begin
    ec = expo_in;
    if (expo_in < EXPO_MIN) begin
      ec = EXPO_MIN;
    end else if (expo_in > EXPO_MAX) begin
      ec = EXPO_MAX;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    applied_d   = applied_q;
    ovr_d       = ovr_q;
    primed_d    = primed_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hs          = cmd_valid_q && cmd.cmd_ready;
    nxt         = next_of(state_q);

    if (state_q == IDLE) begin
      if (frame_new && enable) begin
        pend_d = ec;
        // Skip the bus traffic when the sensor already holds this value.
        if (!(primed_q && (ec == applied_q))) begin
          state_d                  = FIRST;
          cmd_valid_d              = 1'b1;
          busy_d                   = 1'b1;
          {cmd_addr_d, cmd_data_d} = cmd_word(FIRST, ec);
        end
      end
    end else begin
      if (frame_new && enable && (ovr_q != 8'hFF)) begin
        ovr_d = ovr_q + 8'd1;
      end
      if (hs) begin
        state_d = nxt;
        if (nxt == IDLE) begin
          cmd_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          applied_d   = pend_q;
          primed_d    = 1'b1;
        end else begin
          {cmd_addr_d, cmd_data_d} = cmd_word(nxt, pend_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= EXPO_INIT;
      applied_q   <= EXPO_INIT;
      ovr_q       <= 8'h00;
      primed_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= 16'h0000;
      cmd_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      applied_q   <= applied_d;
      ovr_q       <= ovr_d;
      primed_q    <= primed_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd.cmd_valid = cmd_valid_q;
  assign cmd.cmd_addr  = cmd_addr_q;
  assign cmd.cmd_data  = cmd_data_q;
  assign busy          = busy_q;
  assign update_done   = done_q;
  assign applied_expo  = applied_q;
  assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_expo_sensor_writer.sv
// Directed bench for expo_sensor_writer: one group-hold instance (u1) and one plain H/M/L instance (u0).
module tb_expo_sensor_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        frame_new;
  logic        frame_new0;
  logic        rdy;
  logic [23:0] expo_in;
  logic        busy1, done1, busy0, done0;
  logic [23:0] app1, app0;
  logic [7:0]  ovr1, ovr0;

  int checks = 0;
  int errors = 0;
  logic [15:0] la [8];
  logic [7:0]  ld [8];
  int          n;

  always #5 clk = ~clk;

  expo_sensor_writer_if if1();
  expo_sensor_writer_if if0();
  assign if1.cmd_ready = rdy;
  assign if0.cmd_ready = rdy;

  expo_sensor_writer #(.USE_GROUP_HOLD(1'b1)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .frame_new(frame_new), .expo_in(expo_in),
    .cmd(if1), .busy(busy1), .update_done(done1), .applied_expo(app1), .overrun_cnt(ovr1)
  );

  expo_sensor_writer #(.USE_GROUP_HOLD(1'b0)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .frame_new(frame_new0), .expo_in(expo_in),
    .cmd(if0), .busy(busy0), .update_done(done0), .applied_expo(app0), .overrun_cnt(ovr0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit sel, input logic [23:0] e);
    expo_in = e;
    if (sel) frame_new0 = 1'b1;
    else     frame_new  = 1'b1;
    step();
    frame_new  = 1'b0;
    frame_new0 = 1'b0;
  endtask

  // Accepts commands until update_done, optionally stalling each one and injecting overrun strobes.
  task automatic drain(input bit sel, input int stall, input bit inject);
    int          waitc;
    bit          got;
    logic        v;
    logic [15:0] a, a0;
    logic [7:0]  d, d0;
    n = 0; waitc = 0; got = 1'b0; a0 = '0; d0 = '0;
    for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
      v = sel ? if0.cmd_valid : if1.cmd_valid;
      a = sel ? if0.cmd_addr  : if1.cmd_addr;
      d = sel ? if0.cmd_data  : if1.cmd_data;
      frame_new = 1'b0;
      if ((sel ? done0 : done1) === 1'b1) begin
        got = 1'b1;
        chk("valid_low_at_done", v, 0);
        chk("busy_low_at_done", sel ? busy0 : busy1, 0);
      end else if (v === 1'b1) begin
        chk("busy_while_valid", sel ? busy0 : busy1, 1);
        if (waitc == 0) begin
          a0 = a; d0 = d;
        end else begin
          chk("addr_stable", a, a0);
          chk("data_stable", d, d0);
        end
        if (waitc < stall) begin
          rdy = 1'b0;
          if (inject && waitc == 1 && n < 3) begin
            frame_new = 1'b1;
            expo_in   = 24'h000500;
          end
          waitc++;
        end else begin
          rdy = 1'b1;
          if (n < 8) begin
            la[n] = a; ld[n] = d;
          end
          n++;
          waitc = 0;
        end
      end
      if (!got) step();
    end
    chk("seq_done_in_budget", got, 1);
  endtask

  task automatic cmp6(input string tag, input logic [7:0] dh, input logic [7:0] dm, input logic [7:0] dl);
    logic [15:0] ea [6];
    logic [7:0]  ed [6];
    ea = '{16'h3212, 16'h3500, 16'h3501, 16'h3502, 16'h3212, 16'h3212};
    ed = '{8'h00, dh, dm, dl, 8'h10, 8'hA0};
    chk({tag, "_count"}, n, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), la[i], ea[i]);
      chk($sformatf("%s_data%0d", tag, i), ld[i], ed[i]);
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (if1.cmd_valid !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0) seen = 1'b1;
      step();
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; enable = 1'b1; frame_new = 1'b0; frame_new0 = 1'b0; rdy = 1'b0; expo_in = '0;
    step();
    step();
    chk("rst_valid", if1.cmd_valid, 0);
    chk("rst_addr", if1.cmd_addr, 16'h0000);
    chk("rst_data", if1.cmd_data, 8'h00);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_applied", app1, 24'h011264);
    chk("rst_ovr", ovr1, 8'h00);
    chk("rst_valid0", if0.cmd_valid, 0);
    rst = 1'b0;
    step();

    // First frame after reset is written even though it equals the reset value.
    pulse(1'b0, 24'h011264);
    chk("first_valid", if1.cmd_valid, 1);
    chk("first_busy", busy1, 1);
    chk("first_addr", if1.cmd_addr, 16'h3212);
    chk("first_data", if1.cmd_data, 8'h00);
    rdy = 1'b1;
    drain(1'b0, 0, 1'b0);
    cmp6("init", 8'h01, 8'h12, 8'h64);
    chk("init_applied", app1, 24'h011264);
    step();
    chk("done_one_cycle", done1, 0);

    pulse(1'b0, 24'h011264);
    quiet("same_expo_no_cmd", 10);

    pulse(1'b0, 24'hFFFFFF);
    drain(1'b0, 0, 1'b0);
    cmp6("clamp_hi", 8'h0F, 8'hFF, 8'hFF);
    chk("clamp_hi_applied", app1, 24'h0FFFFF);

    pulse(1'b0, 24'h000003);
    drain(1'b0, 0, 1'b0);
    cmp6("clamp_lo", 8'h00, 8'h00, 8'h10);
    chk("clamp_lo_applied", app1, 24'h000010);

    pulse(1'b1, 24'h054321);
    chk("nogh_first_addr", if0.cmd_addr, 16'h3500);
    drain(1'b1, 0, 1'b0);
    chk("nogh_count", n, 3);
    chk("nogh_addr0", la[0], 16'h3500);
    chk("nogh_data0", ld[0], 8'h05);
    chk("nogh_addr1", la[1], 16'h3501);
    chk("nogh_data1", ld[1], 8'h43);
    chk("nogh_addr2", la[2], 16'h3502);
    chk("nogh_data2", ld[2], 8'h21);
    chk("nogh_applied", app0, 24'h054321);

    rdy = 1'b0;
    pulse(1'b0, 24'h000777);
    drain(1'b0, 5, 1'b1);
    cmp6("stall", 8'h00, 8'h07, 8'h77);
    chk("stall_ovr", ovr1, 8'h03);
    chk("stall_applied", app1, 24'h000777);

    rdy = 1'b0;
    pulse(1'b0, 24'h000888);
    frame_new = 1'b1;
    expo_in   = 24'h000999;
    repeat (300) step();
    frame_new = 1'b0;
    chk("ovr_saturate", ovr1, 8'hFF);
    chk("ovr_applied_held", app1, 24'h000777);
    drain(1'b0, 0, 1'b0);
    cmp6("after_ovr", 8'h00, 8'h08, 8'h88);
    chk("after_ovr_applied", app1, 24'h000888);

    rdy = 1'b1;
    pulse(1'b0, 24'h011111);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if1.cmd_valid === 1'b1 && if1.cmd_addr === 16'h3501) found = 1'b1;
      else step();
    end
    chk("reach_wr_m", found, 1);
    rst = 1'b1;
    step();
    chk("midrst_valid", if1.cmd_valid, 0);
    chk("midrst_busy", busy1, 0);
    chk("midrst_applied", app1, 24'h011264);
    chk("midrst_ovr", ovr1, 8'h00);
    rst = 1'b0;
    quiet("midrst_no_cmd", 5);

    enable = 1'b0;
    pulse(1'b0, 24'h000555);
    quiet("disabled_no_cmd", 8);
    chk("disabled_ovr", ovr1, 8'h00);
    enable = 1'b1;

    pulse(1'b0, 24'h011264);
    drain(1'b0, 0, 1'b0);
    cmp6("reprime", 8'h01, 8'h12, 8'h64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/expo_sensor_writer.md
# expo_sensor_writer

Applies the exposure value produced by the auto-exposure loop to the image sensor. On each frame boundary it samples the 24-bit exposure word, clamps it, and emits a sequence of 8-bit register-write commands (addr/data) with a valid/ready handshake to the SCCB master. The sequence is optionally bracketed by sensor group-hold writes so that all three exposure bytes take effect on the same frame. It sits between the auto-exposure block and the SCCB/I2C master in the camera control path.

## Interface
- EXPO_MAX, 24'h0FFFFF: upper clamp; the sensor exposure field is 20 bits.
- EXPO_MIN, 24'h000010: lower clamp.
- EXPO_INIT, 24'h011264: reset value of APPLIED_EXPO.
- REG_EXPO_H, 16'h3500: register receiving {4'h0, e[19:16]}.
- REG_EXPO_M, 16'h3501: register receiving e[15:8].
- REG_EXPO_L, 16'h3502: register receiving e[7:0].
- USE_GROUP_HOLD, 1: 1 wraps writes in group hold; 0 writes H/M/L only.
- REG_GROUP, 16'h3212: group-hold control register.
- CLK  in  1  sole clock.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  when 0, FRAME_NEW is ignored.
- FRAME_NEW  in  1  single-cycle frame-boundary strobe.
- EXPO_IN  in  24  requested exposure, stable around FRAME_NEW.
- CMD_VALID  out  1  command present.
- CMD_ADDR  out  16  sensor register address.
- CMD_DATA  out  8  register data.
- CMD_READY  in  1  master accepts the command when CMD_VALID && CMD_READY.
- BUSY  out  1  a sequence is in progress.
- UPDATE_DONE  out  1  one-cycle pulse after the last command is accepted.
- APPLIED_EXPO  out  24  last fully written (clamped) exposure.
- OVERRUN_CNT  out  8  saturating count of frames missed while busy.

## Operation
- Clamp: ec = min(max(EXPO_IN, EXPO_MIN), EXPO_MAX). Comparisons are unsigned, 24-bit.
- FSM states: IDLE, GH_START, WR_H, WR_M, WR_L, GH_END, GH_LAUNCH.
- IDLE: when FRAME_NEW && ENABLE, latch ec into PEND. If PRIMED && ec == APPLIED_EXPO, stay in IDLE and issue no commands. Otherwise, with USE_GROUP_HOLD=1, go to GH_START; with USE_GROUP_HOLD=0, go to WR_H.
- Commands per state:
  - GH_START: (REG_GROUP, 8'h00)
  - WR_H: (REG_EXPO_H, {4'h0, PEND[19:16]})
  - WR_M: (REG_EXPO_M, PEND[15:8])
  - WR_L: (REG_EXPO_L, PEND[7:0])
  - GH_END: (REG_GROUP, 8'h10)
  - GH_LAUNCH: (REG_GROUP, 8'hA0)
- Each state advances on handshake. The final state is WR_L when USE_GROUP_HOLD=0, otherwise GH_LAUNCH.
- On the final handshake: APPLIED_EXPO <= PEND, PRIMED <= 1, UPDATE_DONE pulses in the next cycle, FSM returns to IDLE.
- PRIMED clears on reset, so the first accepted frame after reset is always written, even if it equals EXPO_INIT.
- FRAME_NEW while not IDLE with ENABLE=1 is an overrun: OVERRUN_CNT increments (saturates at 8'hFF) and EXPO_IN is not captured. This includes FRAME_NEW coinciding with the final handshake.
- ENABLE low during a sequence does not abort it; the sequence runs to completion so group hold is never left open.
- CMD_READY while CMD_VALID=0 has no effect.

## Timing
- Reset values: CMD_VALID=0, CMD_ADDR=0, CMD_DATA=0, BUSY=0, UPDATE_DONE=0, APPLIED_EXPO=EXPO_INIT, OVERRUN_CNT=0, FSM=IDLE, PRIMED=0.
- All outputs are registered.
- FRAME_NEW sampled high at edge k: CMD_VALID, CMD_ADDR and CMD_DATA are valid from edge k+1. BUSY is high from edge k+1.
- CMD_ADDR and CMD_DATA are held stable while CMD_VALID && !CMD_READY.
- After a handshake at edge j, the next command is presented from edge j+1. CMD_VALID may remain high, so back-to-back commands are possible; with CMD_READY tied high, one command is issued per cycle.
- Minimum sequence length: 6 cycles (group hold) or 3 cycles (no group hold).
- After the final handshake at edge j: CMD_VALID=0 and BUSY=0 from edge j+1, UPDATE_DONE=1 for exactly cycle j+1, APPLIED_EXPO updated at edge j+1.
- A new FRAME_NEW is accepted in cycle j+1.
- RST asserted mid-sequence: all state returns to reset values at the next edge, and no further commands are issued.

## Test plan
- After reset, FRAME_NEW with EXPO_IN=24'h011264, CMD_READY=1 -> six commands: 3212/00, 3500/01, 3501/12, 3502/64, 3212/10, 3212/A0; UPDATE_DONE one cycle after; APPLIED_EXPO=011264.
- Repeat FRAME_NEW with the same EXPO_IN -> no CMD_VALID, no UPDATE_DONE. Then EXPO_IN=24'hFFFFFF -> data bytes 0F/FF/FF; APPLIED_EXPO=0FFFFF. Then EXPO_IN=24'h000003 -> data bytes 00/00/10.
- CMD_READY low for 5 cycles per command -> CMD_ADDR/CMD_DATA stable while stalled; order unchanged; BUSY high throughout.
- Three FRAME_NEW strobes during a stalled sequence -> OVERRUN_CNT=3; APPLIED_EXPO is the originally latched value; 300 overruns -> OVERRUN_CNT=FF.
- USE_GROUP_HOLD=0, EXPO_IN=24'h054321 -> exactly three commands 3500/05, 3501/43, 3502/21.
- RST during WR_M -> CMD_VALID=0 next cycle, APPLIED_EXPO=011264; ENABLE=0 with FRAME_NEW -> no commands, no overrun counted.
